// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if - byte handshake between a producer and the UART transmitter.
//   tx_data  : byte to send
//   tx_valid : producer has a byte on tx_data
//   tx_ready : transmitter FIFO can take a byte
// A byte moves on a clock edge where tx_valid && tx_ready.
`timescale 1ns/1ps
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo - 8N1 UART transmitter (LSB first, idle-high) fed by a small FIFO.
// Bit timing CLK_FREQ/BAUD_RATE matches uart_rx so tx can loop into uart_rx.rx.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : uart_tx_fifo_if.slave (tx_data / tx_valid / tx_ready)
//   tx         : serial line, registered
//   tx_busy    : frame in progress or FIFO non-empty
//   fifo_count : bytes waiting in the FIFO (the byte in the shifter is not counted)
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frame).
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_fifo_if.slave                 bus,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  // state    | meaning
  // IDLE     | line high, waiting for a byte in the FIFO
  // START    | start bit (low)
  // DATA     | 8 data bits, LSB first
  // PARITY   | even-parity bit (only with UART_TX_PARITY_EN)
  // STOP     | stop bit (high); pops the next byte on expiry if one is waiting
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, empty, full;

  logic [2:0]    state;
  logic [BW-1:0] baud_cnt;
  logic          baud_done;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign push      = bus.tx_valid && bus.tx_ready && !full;
  assign baud_done = (baud_cnt == BAUD_LAST);

  // The FIFO head is taken either from IDLE or at the end of a stop bit, which
  // is what makes back-to-back frames gapless.
  always_comb begin
    pop = 1'b0;
    if (!empty && ((state == S_IDLE) || (state == S_STOP && baud_done)))
      pop = 1'b1;
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // tx_ready follows the next count so a full FIFO never sees an extra push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.tx_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_next;
      bus.tx_ready <= (count_next != FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          if (baud_done) begin
            state    <= S_DATA;
            tx       <= shift[0];
            shift    <= shift >> 1;
            bit_idx  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_bit;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
      // Loading the next byte overrides the IDLE / stop-expiry assignments above.
      if (pop) begin
        shift    <= mem[rd_ptr];
        state    <= S_START;
        tx       <= 1'b0;
        baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^mem[rd_ptr];
`endif
      end
    end
  end

  assign fifo_count = count;
  assign tx_busy    = (state != S_IDLE) || !empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int WAIT_LIMIT = 2 * 11 * CPB;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // 8N1 line, bit 0 = start bit
    logic       par;    // even parity of data
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx, tx_busy;
  logic [2:0] fifo_count;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  uart_tx_fifo_if bif();

  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif),
    .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] line_exp(input logic [9:0] line, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, line[8:0]};
`else
    return {par & 1'b0, line};
`endif
  endfunction

  task automatic push_byte(input logic [7:0] b, output int seen);
    int g;
    g = 0;
    bif.tx_data  = b;
    bif.tx_valid = 1'b1;
    while (bif.tx_ready !== 1'b1 && g < WAIT_LIMIT) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= WAIT_LIMIT) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: tx_ready stayed %b, expected 1", bif.tx_ready);
    end
    seen = cyc;
    @(posedge clk); #1;
    bif.tx_valid = 1'b0;
  endtask

  task automatic capture_frame(output logic [10:0] bits, output int start_c);
    int g;
    g = 0;
    bits = '0;
    while (tx !== 1'b0 && g < WAIT_LIMIT) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= WAIT_LIMIT) begin
      n_checks++; n_fail++;
      $display("FAIL start_timeout: tx stayed %b, expected 0", tx);
    end
    start_c = cyc;
    repeat (CPB / 2) @(posedge clk);
    #1 bits[0] = tx;
    for (int i = 1; i < NB; i++) begin
      repeat (CPB) @(posedge clk);
      #1 bits[i] = tx;
    end
  endtask

  task automatic wait_idle(output int end_c);
    int g;
    g = 0;
    while (tx_busy !== 1'b0 && g < WAIT_LIMIT) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= WAIT_LIMIT) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: tx_busy stayed %b, expected 0", tx_busy);
    end
    end_c = cyc;
  endtask

  initial begin
    vec_t        vecs[5];
    logic [10:0] bits, bits2;
    logic [10:0] fb[6];
    int          sc6[6];
    logic [7:0]  t3b[6];
    int          sc, sc2, endc, seen, ready_seen;
    logic        bad;

    vecs[0] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[4] = '{8'h81, 10'b1_10000001_0, 1'b0};
    t3b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    bif.tx_data  = 8'h00;
    bif.tx_valid = 1'b0;
    rst_n        = 1'b0;

    // reset state
    repeat (3) @(posedge clk); #1;
    check("rst_tx", tx, 1);
    check("rst_ready", bif.tx_ready, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", bif.tx_ready, 1);
    check("idle_tx", tx, 1);

    // single 0xA5: latency, frame contents, frame length
    push_byte(8'hA5, seen);
    check("lat_tx_hold", tx, 1);
    check("lat_count", fifo_count, 1);
    check("lat_busy", tx_busy, 1);
    @(posedge clk); #1;
    check("lat_tx_fall", tx, 0);
    check("pop_count", fifo_count, 0);
    capture_frame(bits, sc);
    check("frame_a5", bits, line_exp(10'b1_10100101_0, 1'b0));
    wait_idle(endc);
    check("frame_len", endc - sc, NB * CPB);
    check("idle_after_frame", tx, 1);

    // table-driven single frames
    for (int i = 0; i < 5; i++) begin
      push_byte(vecs[i].data, seen);
      capture_frame(bits, sc);
      check($sformatf("frame_vec%0d", i), bits, line_exp(vecs[i].line, vecs[i].par));
      wait_idle(endc);
    end

    // 0xA5 then 0x3C on consecutive cycles: gapless
    push_byte(8'hA5, seen);
    push_byte(8'h3C, seen);
    capture_frame(bits, sc);
    capture_frame(bits2, sc2);
    check("b2b_frame1", bits, line_exp(10'b1_10100101_0, 1'b0));
    check("b2b_frame2", bits2, line_exp(10'b1_00111100_0, 1'b0));
    check("b2b_gapless", sc2 - sc, NB * CPB);
    wait_idle(endc);

    // valid held with 6 bytes: 5 accepted, then ready returns after first pop
    ready_seen = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) push_byte(t3b[i], seen);
        check("full_ready", bif.tx_ready, 0);
        check("full_count", fifo_count, 4);
        push_byte(t3b[5], ready_seen);
      end
      begin
        for (int f = 0; f < 6; f++) capture_frame(fb[f], sc6[f]);
      end
    join
    check("ready_return", ready_seen - sc6[0], NB * CPB);
    for (int f = 0; f < 6; f++)
      check($sformatf("burst_frame%0d", f), fb[f], line_exp({1'b1, t3b[f], 1'b0}, ^t3b[f]));
    wait_idle(endc);

    // reset during data bit 3 of 0xFF with two bytes queued
    push_byte(8'hFF, seen);
    push_byte(8'h11, seen);
    push_byte(8'h22, seen);
    repeat (4 * CPB + CPB / 2 - 1) @(posedge clk);
    #1;
    check("mid_bit3_tx", tx, 1);
    check("mid_bit3_count", fifo_count, 2);
    check("mid_bit3_busy", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_count", fifo_count, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_ready", bif.tx_ready, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bad = 1'b0;
    repeat (3 * CPB) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) bad = 1'b1;
    end
    check("no_resume", bad, 0);
    push_byte(8'h5A, seen);
    capture_frame(bits, sc);
    check("post_rst_frame", bits, line_exp(10'b1_01011010_0, 1'b0));
    wait_idle(endc);
    check("post_rst_len", endc - sc, NB * CPB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
